// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter that lets NREQ write-domain producers share one async-FIFO write port.
// Latency: 1 arbitration cycle in IDLE, then up to BURST words on consecutive cycles.
// Backpressure: wfull drops gnt/winc combinationally; the grant holds (beat frozen) until it clears.
module fifo_wr_arb #(
    parameter int DSIZE = 8,
    parameter int NREQ  = 4,
    parameter int BURST = 4,
    localparam int OW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*DSIZE-1:0] req_data,
    input  logic                  wfull,
    output logic [NREQ-1:0]       gnt,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    output logic [OW-1:0]         owner,
    output logic                  busy
);

    localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t          state, state_nxt;
    logic [OW-1:0]   last, last_nxt;
    logic [OW-1:0]   owner_nxt;
    logic [BW-1:0]   beat, beat_nxt;
    logic [OW-1:0]   pick;
    logic            pick_vld;
    logic            req_own;

    // Circular priority search starting one past the last finished owner.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pick_vld && req[i] && (((int'(last) + k) % NREQ) == i)) begin
                    pick     = OW'(i);
                    pick_vld = 1'b1;
                end
            end
        end
    end

    // Owner's request bit and data slice, selected with constant indices only.
    always_comb begin
        req_own = 1'b0;
        wdata   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner == OW'(i)) begin
                req_own = req[i];
                wdata   = req_data[i*DSIZE +: DSIZE];
            end
        end
    end

    // Next-state and Moore/Mealy outputs; grant outputs are gated by wfull with no lookahead.
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        owner_nxt = owner;
        beat_nxt  = beat;
        gnt       = '0;
        winc      = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    owner_nxt = pick;
                    beat_nxt  = '0;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                busy = 1'b1;
                for (int i = 0; i < NREQ; i++) begin
                    gnt[i] = (owner == OW'(i)) & ~wfull;
                end
                winc = req_own & ~wfull;
                if (winc) begin
                    if (beat == BW'(BURST - 1)) begin
                        last_nxt  = owner;
                        state_nxt = IDLE;
                    end else begin
                        beat_nxt = beat + BW'(1);
                    end
                end else if (!req_own) begin
                    // Requester let go before its burst was used up.
                    last_nxt  = owner;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register; last resets to NREQ-1 so requester 0 wins the first arbitration.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state <= IDLE;
            last  <= OW'(NREQ - 1);
            owner <= '0;
            beat  <= '0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            owner <= owner_nxt;
            beat  <= beat_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: directed table on a 4x4 instance plus random wfull on a 2x1 instance.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
// A scoreboard tracks per-requester word order and grant alternation.
module tb_fifo_wr_arb;

    logic        wclk;
    logic        wrst_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        wfull;
    logic [3:0]  gnt;
    logic        winc;
    logic [7:0]  wdata;
    logic [1:0]  owner;
    logic        busy;

    logic [1:0]  req2;
    logic [15:0] req_data2;
    logic        wfull2;
    logic [1:0]  gnt2;
    logic        winc2;
    logic [7:0]  wdata2;
    logic [0:0]  owner2;
    logic        busy2;

    int checks = 0;
    int passes = 0;

    logic [3:0] cnt [4];
    logic [6:0] cnt2 [2];

    fifo_wr_arb #(.DSIZE(8), .NREQ(4), .BURST(4)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .req(req), .req_data(req_data), .wfull(wfull),
        .gnt(gnt), .winc(winc), .wdata(wdata), .owner(owner), .busy(busy)
    );

    fifo_wr_arb #(.DSIZE(8), .NREQ(2), .BURST(1)) dut2 (
        .wclk(wclk), .wrst_n(wrst_n), .req(req2), .req_data(req_data2), .wfull(wfull2),
        .gnt(gnt2), .winc(winc2), .wdata(wdata2), .owner(owner2), .busy(busy2)
    );

    initial begin
        wclk = 1'b0;
        forever #5 wclk = ~wclk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within limit");
        $fatal(1);
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    task automatic drive_data();
        for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = {4'(i), cnt[i]};
        for (int i = 0; i < 2; i++) req_data2[i*8 +: 8] = {1'(i), cnt2[i]};
    endtask

    // Called at negedge: records handshakes, crosses the edge, then presents the next words.
    task automatic adv();
        logic [3:0] h;
        logic [1:0] h2;
        h  = req & gnt;
        h2 = req2 & gnt2;
        @(posedge wclk);
        #1;
        for (int i = 0; i < 4; i++) if (h[i]) cnt[i]++;
        for (int i = 0; i < 2; i++) if (h2[i]) cnt2[i]++;
        drive_data();
    endtask

    task automatic do_reset();
        req    = '0;
        req2   = '0;
        wfull  = 1'b0;
        wfull2 = 1'b0;
        wrst_n = 1'b0;
        for (int i = 0; i < 4; i++) cnt[i] = '0;
        for (int i = 0; i < 2; i++) cnt2[i] = '0;
        drive_data();
        repeat (2) @(posedge wclk);
        #1;
        wrst_n = 1'b1;
    endtask

    // Per-cycle invariants and requester-protocol assertion.
    logic [3:0]  prev_req;
    logic [3:0]  prev_hs;
    logic [31:0] prev_data;
    initial begin
        prev_req  = '0;
        prev_hs   = '0;
        prev_data = '0;
    end
    always @(negedge wclk) begin
        if (wrst_n) begin
            chk("onehot0_gnt", int'($onehot0(gnt)), 1);
            chk("onehot0_gnt2", int'($onehot0(gnt2)), 1);
            if (winc) begin
                chk("winc_wfull", int'(wfull), 0);
                chk("winc_gnt_owner", int'(gnt[owner]), 1);
            end
            if (winc2) begin
                chk("winc2_wfull", int'(wfull2), 0);
                chk("winc2_gnt_owner", int'(gnt2[owner2]), 1);
            end
            for (int i = 0; i < 4; i++) begin
                if (prev_req[i] && !prev_hs[i] && req[i])
                    assert (req_data[i*8 +: 8] == prev_data[i*8 +: 8])
                    else $error("FAIL req_hold: requester %0d data changed before gnt", i);
            end
        end
        prev_req  = req;
        prev_hs   = req & gnt;
        prev_data = req_data;
    end

    typedef struct {
        logic [3:0] req;
        logic       wfull;
        logic [3:0] gnt;
        logic       winc;
        logic [7:0] wdata;
        logic [1:0] owner;
        logic       busy;
    } vec_t;
    vec_t tbl[$];

    task automatic v(input logic [3:0] r, input logic wf, input logic [3:0] g, input logic w,
                     input logic [7:0] d, input logic [1:0] o, input logic b);
        vec_t t;
        t.req = r; t.wfull = wf; t.gnt = g; t.winc = w; t.wdata = d; t.owner = o; t.busy = b;
        tbl.push_back(t);
    endtask

    initial begin
        int o;
        int m [4];
        int m0;
        int m2 [2];
        int nw;
        int nhs;
        logic [0:0] last_w;

        wrst_n    = 1'b0;
        req       = '0;
        req2      = '0;
        wfull     = 1'b0;
        wfull2    = 1'b0;
        req_data  = '0;
        req_data2 = '0;

        // Single requester burst of 4, then early release by 1 with 3 waiting, then a wfull stall on 2.
        v(4'h1, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0);
        v(4'h1, 1'b0, 4'h1, 1'b1, 8'h00, 2'd0, 1'b1);
        v(4'h1, 1'b0, 4'h1, 1'b1, 8'h01, 2'd0, 1'b1);
        v(4'h1, 1'b0, 4'h1, 1'b1, 8'h02, 2'd0, 1'b1);
        v(4'h1, 1'b0, 4'h1, 1'b1, 8'h03, 2'd0, 1'b1);
        v(4'h0, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0);
        v(4'ha, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0);
        v(4'ha, 1'b0, 4'h2, 1'b1, 8'h10, 2'd1, 1'b1);
        v(4'h8, 1'b0, 4'h2, 1'b0, 8'h00, 2'd1, 1'b1);
        v(4'h8, 1'b0, 4'h0, 1'b0, 8'h00, 2'd1, 1'b0);
        v(4'h8, 1'b0, 4'h8, 1'b1, 8'h30, 2'd3, 1'b1);
        v(4'h0, 1'b0, 4'h8, 1'b0, 8'h00, 2'd3, 1'b1);
        v(4'h0, 1'b0, 4'h0, 1'b0, 8'h00, 2'd3, 1'b0);
        v(4'h4, 1'b0, 4'h0, 1'b0, 8'h00, 2'd3, 1'b0);
        v(4'h4, 1'b0, 4'h4, 1'b1, 8'h20, 2'd2, 1'b1);
        v(4'h4, 1'b0, 4'h4, 1'b1, 8'h21, 2'd2, 1'b1);
        for (int i = 0; i < 5; i++) v(4'h4, 1'b1, 4'h0, 1'b0, 8'h00, 2'd2, 1'b1);
        v(4'h4, 1'b0, 4'h4, 1'b1, 8'h22, 2'd2, 1'b1);
        v(4'h4, 1'b0, 4'h4, 1'b1, 8'h23, 2'd2, 1'b1);
        v(4'h0, 1'b0, 4'h0, 1'b0, 8'h00, 2'd2, 1'b0);

        // Reset state
        do_reset();
        @(negedge wclk);
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_winc", int'(winc), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_owner", int'(owner), 0);
        chk("rst_busy2", int'(busy2), 0);
        adv();

        // Directed table
        foreach (tbl[n]) begin
            req   = tbl[n].req;
            wfull = tbl[n].wfull;
            @(negedge wclk);
            chk($sformatf("tbl%0d_gnt", n), int'(gnt), int'(tbl[n].gnt));
            chk($sformatf("tbl%0d_winc", n), int'(winc), int'(tbl[n].winc));
            chk($sformatf("tbl%0d_owner", n), int'(owner), int'(tbl[n].owner));
            chk($sformatf("tbl%0d_busy", n), int'(busy), int'(tbl[n].busy));
            if (tbl[n].winc) chk($sformatf("tbl%0d_wdata", n), int'(wdata), int'(tbl[n].wdata));
            adv();
        end

        // All four requesting: round-robin order 0,1,2,3,0 with 4 beats and 1 idle cycle each
        do_reset();
        req = 4'hf;
        o = 0;
        for (int i = 0; i < 4; i++) m[i] = 0;
        for (int g = 0; g < 5; g++) begin
            @(negedge wclk);
            chk("rr_idle_busy", int'(busy), 0);
            chk("rr_idle_gnt", int'(gnt), 0);
            adv();
            for (int b = 0; b < 4; b++) begin
                @(negedge wclk);
                chk("rr_gnt", int'(gnt), 1 << o);
                chk("rr_winc", int'(winc), 1);
                chk("rr_owner", int'(owner), o);
                chk("rr_wdata", int'(wdata), o * 16 + (m[o] % 16));
                m[o]++;
                adv();
            end
            o = (o + 1) % 4;
        end

        // Reset pulse mid-burst: outputs drop immediately, burst restarts from beat 0
        do_reset();
        req = 4'h1;
        m0 = 0;
        @(negedge wclk);
        chk("mr_idle_busy", int'(busy), 0);
        adv();
        @(negedge wclk);
        chk("mr_pre_winc", int'(winc), 1);
        chk("mr_pre_wdata", int'(wdata), m0);
        m0++;
        adv();
        #2;
        wrst_n = 1'b0;
        #1;
        chk("mr_gnt", int'(gnt), 0);
        chk("mr_winc", int'(winc), 0);
        chk("mr_busy", int'(busy), 0);
        chk("mr_owner", int'(owner), 0);
        @(negedge wclk);
        adv();
        wrst_n = 1'b1;
        @(negedge wclk);
        chk("mr_post_idle", int'(busy), 0);
        adv();
        for (int b = 0; b < 4; b++) begin
            @(negedge wclk);
            chk("mr_gnt_post", int'(gnt), 1);
            chk("mr_wdata_post", int'(wdata), m0);
            m0++;
            adv();
        end
        @(negedge wclk);
        chk("mr_end_idle", int'(busy), 0);
        req = 4'h0;
        adv();

        // Two requesters, single-word bursts, random wfull
        req2 = 2'b11;
        nw = 0;
        nhs = 0;
        m2[0] = 0;
        m2[1] = 0;
        last_w = 1'b0;
        for (int c = 0; c < 400; c++) begin
            wfull2 = 1'($urandom_range(0, 1));
            @(negedge wclk);
            nhs += $countones(req2 & gnt2);
            if (winc2) begin
                chk("rnd_wdata", int'(wdata2), int'(owner2) * 128 + (m2[owner2] % 128));
                if (nw > 0) chk("rnd_alternate", int'(owner2 != last_w), 1);
                last_w = owner2;
                m2[owner2]++;
                nw++;
            end
            adv();
        end
        chk("rnd_hs_eq_winc", nhs, nw);
        chk("rnd_balance", int'((m2[0] - m2[1] <= 1) && (m2[1] - m2[0] <= 1)), 1);
        chk("rnd_progress", int'(nw > 60), 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
